// File: rtl/pixel_framebuffer_pkg.sv
// Shared geometry, address helper and clear-engine state encoding for the
// 160x120 pixel frame store.
package pixel_framebuffer_pkg;

    localparam int FB_WIDTH    = 160;
    localparam int FB_HEIGHT   = 120;
    localparam int FB_PIXELS   = 19200;
    localparam int COLOUR_BITS = 18;
    localparam int ADDR_BITS   = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } clear_state_e;

    // y*160 + x built from shifts: 160 = 128 + 32.
    function automatic logic [ADDR_BITS-1:0] pixel_addr(input logic [7:0] x,
                                                        input logic [6:0] y);
        logic [ADDR_BITS-1:0] x_ext;
        logic [ADDR_BITS-1:0] y_ext;
        x_ext = {{(ADDR_BITS-8){1'b0}}, x};
        y_ext = {{(ADDR_BITS-7){1'b0}}, y};
        return (y_ext << 7) + (y_ext << 5) + x_ext;
    endfunction

endpackage

// File: rtl/pixel_framebuffer_fb_ram.sv
// Simple dual-port frame store: one write port, one registered read port.
// A read of the address being written returns the previous contents.
module pixel_framebuffer_fb_ram
    import pixel_framebuffer_pkg::*;
(
    input  logic                   clock,
    input  logic                   wr_en,
    input  logic [ADDR_BITS-1:0]   wr_addr,
    input  logic [COLOUR_BITS-1:0] wr_data,
    input  logic                   rd_en,
    input  logic [ADDR_BITS-1:0]   rd_addr,
    output logic [COLOUR_BITS-1:0] rd_data
);

    logic [COLOUR_BITS-1:0] mem [FB_PIXELS];
    logic [COLOUR_BITS-1:0] rd_data_q;

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/pixel_framebuffer.sv
// Pixel frame store with drawer write port, full-screen clear engine and
// a free-running raster scan-out port.
module pixel_framebuffer
    import pixel_framebuffer_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic [7:0]             vga_x,
    input  logic [6:0]             vga_y,
    input  logic [COLOUR_BITS-1:0] vga_colour,
    input  logic                   vga_write,
    input  logic                   clear_start,
    input  logic [COLOUR_BITS-1:0] clear_colour,
    output logic                   clear_done,
    output logic                   busy,
    input  logic                   scan_enable,
    output logic [7:0]             scan_x,
    output logic [6:0]             scan_y,
    output logic [COLOUR_BITS-1:0] scan_colour,
    output logic                   scan_valid,
    output logic                   scan_frame_start,
    output logic [7:0]             drop_count
);

    clear_state_e           state_q, state_d;
    logic [ADDR_BITS-1:0]   fill_q, fill_d;
    logic [COLOUR_BITS-1:0] fill_colour_q, fill_colour_d;
    logic [7:0]             drop_q, drop_d;
    logic [7:0]             raster_x_q, raster_x_d;
    logic [6:0]             raster_y_q, raster_y_d;
    logic                   scan_valid_q;
    logic [7:0]             scan_x_q;
    logic [6:0]             scan_y_q;

    logic                   in_range;
    logic                   wr_en;
    logic [ADDR_BITS-1:0]   wr_addr;
    logic [COLOUR_BITS-1:0] wr_data;
    logic [COLOUR_BITS-1:0] rd_data;

    assign in_range = (vga_x < 8'(FB_WIDTH)) && (vga_y < 7'(FB_HEIGHT));

    always_comb begin
        state_d       = state_q;
        fill_d        = fill_q;
        fill_colour_d = fill_colour_q;
        drop_d        = drop_q;
        wr_en         = 1'b0;
        wr_addr       = pixel_addr(vga_x, vga_y);
        wr_data       = vga_colour;
        unique case (state_q)
            ST_IDLE: begin
                if (vga_write) begin
                    if (in_range) begin
                        wr_en = 1'b1;
                    end else if (drop_q != 8'hFF) begin
                        drop_d = drop_q + 8'd1;
                    end
                end
                if (clear_start) begin
                    state_d       = ST_CLEAR;
                    fill_d        = '0;
                    fill_colour_d = clear_colour;
                end
            end
            ST_CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = fill_q;
                wr_data = fill_colour_q;
                fill_d  = fill_q + ADDR_BITS'(1);
                if (fill_q == ADDR_BITS'(FB_PIXELS - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        raster_x_d = raster_x_q;
        raster_y_d = raster_y_q;
        if (scan_enable) begin
            if (raster_x_q == 8'(FB_WIDTH - 1)) begin
                raster_x_d = '0;
                raster_y_d = (raster_y_q == 7'(FB_HEIGHT - 1)) ? '0 : raster_y_q + 7'd1;
            end else begin
                raster_x_d = raster_x_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            fill_q        <= '0;
            fill_colour_q <= '0;
            drop_q        <= '0;
            raster_x_q    <= '0;
            raster_y_q    <= '0;
            scan_valid_q  <= 1'b0;
            scan_x_q      <= '0;
            scan_y_q      <= '0;
        end else begin
            state_q       <= state_d;
            fill_q        <= fill_d;
            fill_colour_q <= fill_colour_d;
            drop_q        <= drop_d;
            raster_x_q    <= raster_x_d;
            raster_y_q    <= raster_y_d;
            scan_valid_q  <= scan_enable;
            scan_x_q      <= raster_x_q;
            scan_y_q      <= raster_y_q;
        end
    end

    // Reset must also stop an in-flight fill from writing on the reset edge.
    pixel_framebuffer_fb_ram u_fb_ram (
        .clock   (clock),
        .wr_en   (wr_en && !reset),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (scan_enable),
        .rd_addr (pixel_addr(raster_x_q, raster_y_q)),
        .rd_data (rd_data)
    );

    assign busy             = (state_q == ST_CLEAR);
    assign clear_done       = (state_q == ST_DONE);
    assign drop_count       = drop_q;
    assign scan_valid       = scan_valid_q;
    assign scan_x           = scan_x_q;
    assign scan_y           = scan_y_q;
    assign scan_colour      = scan_valid_q ? rd_data : '0;
    assign scan_frame_start = scan_valid_q && (scan_x_q == 8'd0) && (scan_y_q == 7'd0);

endmodule

// File: tb/tb_pixel_framebuffer.sv
// Self-checking bench for pixel_framebuffer: per-cycle comparison against a
// linear-index frame model, plus directed table and corner sequences.
module tb_pixel_framebuffer;

    localparam int W = 160;
    localparam int H = 120;
    localparam int N = 19200;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [17:0] vga_colour;
    logic        vga_write;
    logic        clear_start;
    logic [17:0] clear_colour;
    logic        clear_done;
    logic        busy;
    logic        scan_enable;
    logic [7:0]  scan_x;
    logic [6:0]  scan_y;
    logic [17:0] scan_colour;
    logic        scan_valid;
    logic        scan_frame_start;
    logic [7:0]  drop_count;

    always #5 clock = ~clock;

    pixel_framebuffer dut (
        .clock            (clock),
        .reset            (reset),
        .vga_x            (vga_x),
        .vga_y            (vga_y),
        .vga_colour       (vga_colour),
        .vga_write        (vga_write),
        .clear_start      (clear_start),
        .clear_colour     (clear_colour),
        .clear_done       (clear_done),
        .busy             (busy),
        .scan_enable      (scan_enable),
        .scan_x           (scan_x),
        .scan_y           (scan_y),
        .scan_colour      (scan_colour),
        .scan_valid       (scan_valid),
        .scan_frame_start (scan_frame_start),
        .drop_count       (drop_count)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: frame as a flat array indexed by raster position.
    logic [17:0] mem_m [N];
    bit          known [N];
    int          age;        // 0: idle, 1..N: fill step, N+1: done cycle
    logic [17:0] ccol;
    int          drop_m;
    int          pos;
    bit          exp_valid;
    bit          exp_known;
    int          exp_x;
    int          exp_y;
    logic [17:0] exp_col;

    logic [17:0] seen [N];
    int cycle = 0;
    int busy_cycles = 0;
    int done_cnt = 0;
    int fs_prev = -1;
    int fs_last = -1;

    typedef struct {
        logic [7:0]  x;
        logic [6:0]  y;
        logic [17:0] c;
        bit          ok;
    } wr_vec_t;
    wr_vec_t vecs [8];

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
            if (errors >= 100) begin
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    endfunction

    function automatic void model_edge();
        int a;
        if (reset) begin
            age = 0;
            drop_m = 0;
            pos = 0;
            exp_valid = 0;
            return;
        end
        exp_valid = scan_enable;
        if (scan_enable) begin
            exp_x = pos % W;
            exp_y = pos / W;
            exp_col = mem_m[pos];
            exp_known = known[pos];
            pos = (pos + 1) % N;
        end
        if (age == 0) begin
            if (vga_write) begin
                if (int'(vga_x) < W && int'(vga_y) < H) begin
                    a = int'(vga_y) * W + int'(vga_x);
                    mem_m[a] = vga_colour;
                    known[a] = 1;
                end else if (drop_m < 255) begin
                    drop_m++;
                end
            end
            if (clear_start) begin
                age = 1;
                ccol = clear_colour;
            end
        end else if (age <= N) begin
            mem_m[age-1] = ccol;
            known[age-1] = 1;
            age++;
        end else begin
            age = 0;
        end
    endfunction

    function automatic void check_outputs();
        check("busy", busy, (age >= 1 && age <= N));
        check("clear_done", clear_done, (age == N + 1));
        check("drop_count", drop_count, drop_m);
        check("scan_valid", scan_valid, exp_valid);
        if (exp_valid) begin
            check("scan_x", scan_x, exp_x);
            check("scan_y", scan_y, exp_y);
            check("scan_frame_start", scan_frame_start, (exp_x == 0 && exp_y == 0));
            if (exp_known) check("scan_colour", scan_colour, exp_col);
            seen[exp_y*W + exp_x] = scan_colour;
        end else begin
            check("scan_frame_start_idle", scan_frame_start, 0);
        end
        if (busy) busy_cycles++;
        if (clear_done) done_cnt++;
        if (scan_frame_start) begin
            fs_prev = fs_last;
            fs_last = cycle;
        end
    endfunction

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        cycle++;
        check_outputs();
    endtask

    initial begin
        int exp_tbl;
        vecs[0] = '{8'd10,  7'd20,  18'h3F03F, 1'b1};
        vecs[1] = '{8'd160, 7'd5,   18'h11111, 1'b0};
        vecs[2] = '{8'd5,   7'd120, 18'h22222, 1'b0};
        vecs[3] = '{8'd159, 7'd119, 18'h12345, 1'b1};
        vecs[4] = '{8'd0,   7'd0,   18'h2AAAA, 1'b1};
        vecs[5] = '{8'd255, 7'd127, 18'h33333, 1'b0};
        vecs[6] = '{8'd159, 7'd0,   18'h15555, 1'b1};
        vecs[7] = '{8'd0,   7'd119, 18'h00001, 1'b1};
        for (int i = 0; i < N; i++) known[i] = 0;
        age = 0; drop_m = 0; pos = 0; exp_valid = 0; ccol = '0;

        reset = 1; vga_x = 0; vga_y = 0; vga_colour = 0; vga_write = 0;
        clear_start = 0; clear_colour = 0; scan_enable = 0;
        #1;
        repeat (3) step();
        check("reset_scan", {scan_x, scan_y, scan_colour, scan_valid, scan_frame_start}, 0);
        check("reset_ctrl", {clear_done, busy, drop_count}, 0);
        reset = 0;

        // Full clear with the scan running alongside.
        busy_cycles = 0; done_cnt = 0;
        clear_colour = 18'h00FC0; clear_start = 1; scan_enable = 1;
        step();
        clear_start = 0;
        repeat (N + 2) step();
        check("clear_busy_cycles", busy_cycles, N);
        check("clear_done_pulses", done_cnt, 1);

        // Table of single-pixel writes, legal and out of range.
        scan_enable = 0;
        exp_tbl = 0;
        for (int i = 0; i < 8; i++) begin
            vga_x = vecs[i].x; vga_y = vecs[i].y; vga_colour = vecs[i].c; vga_write = 1;
            step();
            vga_write = 0;
            if (!vecs[i].ok) exp_tbl++;
            check("tbl_drop", drop_count, exp_tbl);
        end
        scan_enable = 1;
        repeat (N) step();
        scan_enable = 0;
        check("pix_10_20", seen[20*W + 10], 18'h3F03F);
        check("pix_11_20", seen[20*W + 11], 18'h00FC0);
        check("pix_last", seen[N-1], 18'h12345);
        check("pix_first", seen[0], 18'h2AAAA);

        // Clear aborted by reset after 5000 fill cycles, with ignored writes.
        clear_colour = 18'h3F000; clear_start = 1;
        vga_write = 1; vga_x = 8'd200; vga_y = 7'd3; vga_colour = 18'h0000F;
        step();
        clear_start = 0; vga_write = 0;
        check("same_cycle_drop", drop_count, 4);
        repeat (9) step();
        vga_write = 1; vga_x = 0; vga_y = 0; vga_colour = 18'h3FFFF;
        step();
        vga_write = 0;
        check("ignored_write_drop", drop_count, 4);
        repeat (4990) step();
        done_cnt = 0;
        reset = 1;
        step();
        check("abort_busy", busy, 0);
        check("abort_done", clear_done, 0);
        reset = 0;
        scan_enable = 1; fs_prev = -1; fs_last = -1;
        repeat (N + 1) step();
        scan_enable = 0;
        check("frame_interval", fs_last - fs_prev, N);
        check("abort_no_done", done_cnt, 0);
        check("abort_pix0", seen[0], 18'h3F000);
        check("abort_pix4999", seen[4999], 18'h3F000);
        check("abort_pix5000", seen[5000], 18'h00FC0);
        check("abort_pix_last", seen[N-1], 18'h12345);

        // Random writes and scan, often aimed at the pixel being read.
        for (int k = 0; k < 3000; k++) begin
            scan_enable = ($urandom_range(0, 3) != 0);
            vga_write = 1'($urandom_range(0, 1));
            vga_colour = 18'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                vga_x = 8'(pos % W);
                vga_y = 7'(pos / W);
            end else begin
                vga_x = 8'($urandom_range(0, 175));
                vga_y = 7'($urandom_range(0, 127));
            end
            step();
        end
        vga_write = 0; scan_enable = 0;

        // Drop counter saturation.
        vga_write = 1; vga_x = 8'd170; vga_y = 7'd0;
        repeat (300) step();
        vga_write = 0;
        step();
        check("drop_saturated", drop_count, 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
